// File: rtl/hdmi_sync_pkg.sv
// Shared definitions for the multi-channel HDMI word aligner: TMDS control
// tokens, the per-channel search state encoding and a token matcher.
package hdmi_sync_pkg;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0ab;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2ab;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
    endfunction

endpackage

// File: rtl/hdmi_slip_search.sv
// One channel of the aligner: two-word history, token hit flag and the
// SEARCH/VERIFY/LOCKED slip search, advanced only on the shared window-end strobe.
module hdmi_slip_search
    import hdmi_sync_pkg::*;
#(
    parameter int W      = 10,
    parameter int SW     = $clog2(W),
    parameter int LOCK_N = 4,
    parameter int MISS_N = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    i_data,
    input  logic            i_win_end,
    output logic [2*W-1:0]  o_hist,
    output logic [SW-1:0]   o_slip,
    output logic            o_locked,
    output logic            o_drop
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int MW = $clog2(MISS_N + 1);

    logic [W-1:0]   cur_q, cur_d;
    logic [W-1:0]   prev_q, prev_d;
    logic [SW-1:0]  slip_q, slip_d, slip_inc;
    sync_state_e    state_q, state_d;
    logic [GW-1:0]  good_q, good_d, good_inc;
    logic [MW-1:0]  miss_q, miss_d, miss_inc;
    logic           hit_q, hit_d;
    logic           locked_q, locked_d;
    logic [2*W-1:0] hist;
    logic [W-1:0]   aligned;
    logic           match;
    logic           hit_any;

    assign hist     = {cur_q, prev_q};
    assign o_hist   = hist;
    assign o_slip   = slip_q;
    assign o_locked = locked_q;

    always_comb begin
        cur_d   = i_data;
        prev_d  = cur_q;
        aligned = W'(hist >> slip_q);
        match   = is_ctrl_token(10'(aligned));
        // A token seen on the window-end cycle itself still counts for that window.
        hit_any = hit_q | match;
    end

    always_comb begin
        state_d  = state_q;
        slip_d   = slip_q;
        good_d   = good_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        hit_d    = hit_any;
        o_drop   = 1'b0;
        slip_inc = (slip_q >= SW'(W - 1)) ? '0 : slip_q + 1'b1;
        good_inc = (good_q >= GW'(LOCK_N)) ? good_q : good_q + 1'b1;
        miss_inc = (miss_q >= MW'(MISS_N)) ? miss_q : miss_q + 1'b1;

        if (i_win_end) begin
            hit_d = 1'b0;
            case (state_q)
                SEARCH: begin
                    if (hit_any) begin
                        state_d = VERIFY;
                        good_d  = GW'(1);
                    end else begin
                        slip_d  = slip_inc;
                    end
                end
                VERIFY: begin
                    if (hit_any) begin
                        good_d = good_inc;
                        if (good_inc >= GW'(LOCK_N)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        slip_d  = slip_inc;
                        good_d  = '0;
                    end
                end
                LOCKED: begin
                    if (hit_any) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc >= MW'(MISS_N)) begin
                            state_d  = SEARCH;
                            locked_d = 1'b0;
                            slip_d   = slip_inc;
                            miss_d   = '0;
                            good_d   = '0;
                            o_drop   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q    <= '0;
            prev_q   <= '0;
            slip_q   <= '0;
            state_q  <= SEARCH;
            good_q   <= '0;
            miss_q   <= '0;
            hit_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            prev_q   <= prev_d;
            slip_q   <= slip_d;
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            hit_q    <= hit_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: rtl/hdmi_multisync.sv
// NCH-channel HDMI word aligner: shared window counter, per-channel slip search,
// auto/manual slip select into the output register. HDMISYNC_LOSSCOUNT_EN adds o_loss_count.
module hdmi_multisync
    import hdmi_sync_pkg::*;
#(
    parameter int  NCH     = 3,
    parameter int  W       = 10,
    parameter int  WIN_LG2 = 10,
    parameter int  LOCK_N  = 4,
    parameter int  MISS_N  = 2,
    localparam int SW      = $clog2(W)
) (
    input  logic              i_pix_clk,
    input  logic              i_reset,
    input  logic              i_automatic_sync,
    input  logic [NCH*SW-1:0] i_manual_slip,
    input  logic [NCH*W-1:0]  i_data,
    output logic [NCH*W-1:0]  o_data,
    output logic [NCH*SW-1:0] o_slip,
    output logic [NCH-1:0]    o_locked,
    output logic              o_all_locked
`ifdef HDMISYNC_LOSSCOUNT_EN
    ,
    output logic [15:0]       o_loss_count
`endif
);

    logic [WIN_LG2-1:0]          win_q, win_d;
    logic                        win_end;
    logic [NCH-1:0][2*W-1:0]     hist;
    logic [NCH-1:0][SW-1:0]      auto_slip;
    logic [NCH-1:0][SW-1:0]      man_slip;
    logic [NCH-1:0][SW-1:0]      sel_slip;
    logic [NCH-1:0]              locked;
    logic [NCH-1:0]              drop;
    logic [NCH-1:0][W-1:0]       data_q, data_d;
    logic                        all_locked_q, all_locked_d;

    assign win_end = &win_q;
    assign win_d   = win_q + 1'b1;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        hdmi_slip_search #(
            .W      (W),
            .SW     (SW),
            .LOCK_N (LOCK_N),
            .MISS_N (MISS_N)
        ) u_search (
            .clk       (i_pix_clk),
            .reset     (i_reset),
            .i_data    (i_data[k*W +: W]),
            .i_win_end (win_end),
            .o_hist    (hist[k]),
            .o_slip    (auto_slip[k]),
            .o_locked  (locked[k]),
            .o_drop    (drop[k])
        );
    end

    always_comb begin
        man_slip = '0;
        sel_slip = '0;
        data_d   = '0;
        for (int k = 0; k < NCH; k++) begin
            // Out-of-range software slips pin to the last valid rotation.
            man_slip[k] = (i_manual_slip[k*SW +: SW] >= SW'(W - 1)) ? SW'(W - 1)
                                                                     : i_manual_slip[k*SW +: SW];
            sel_slip[k] = i_automatic_sync ? auto_slip[k] : man_slip[k];
            data_d[k]   = W'(hist[k] >> sel_slip[k]);
        end
        all_locked_d = &locked;
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            win_q        <= '0;
            data_q       <= '0;
            all_locked_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            data_q       <= data_d;
            all_locked_q <= all_locked_d;
        end
    end

    assign o_data       = data_q;
    assign o_slip       = auto_slip;
    assign o_locked     = locked;
    assign o_all_locked = all_locked_q;

`ifdef HDMISYNC_LOSSCOUNT_EN
    localparam int DW = $clog2(NCH + 1);

    logic [15:0]   loss_q, loss_d;
    logic [16:0]   loss_sum;
    logic [DW-1:0] n_drop;

    always_comb begin
        n_drop = '0;
        for (int k = 0; k < NCH; k++) begin
            n_drop = n_drop + DW'(drop[k]);
        end
        loss_sum = {1'b0, loss_q} + 17'(n_drop);
        loss_d   = loss_sum[16] ? 16'hffff : loss_sum[15:0];
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign o_loss_count = loss_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule
